// File: rtl/codificador_4a2.sv
// codificador_4a2 -- sticky 4-to-2 priority encoder with an acknowledge handshake.
//
// Request strobes on Entrada are latched into a pending register while Enable
// is high. When the encoder is idle and something is pending, it picks the
// highest-priority pending line, presents its index on Salida and raises
// Valido. The code stays frozen until the consumer acknowledges it. The Ack
// clears that line's pending bit, counts one served code and returns the
// encoder to idle. Valido is therefore low for at least one cycle between
// two consecutive codes.
//
// Handshake: a code transfers on a rising edge of Reloj where Valido=1 and
// Ack=1. Ack while Valido=0 has no effect. Valido never drops without an Ack,
// except on Reset.
//
// Parameters:
//   ALTA_PRIMERO  1: Entrada[3] has the highest priority; 0: Entrada[0] does.
// Ports:
//   Reloj        in   clock, rising edge
//   Reset        in   asynchronous, active-high
//   Entrada[3:0] in   request strobes, one per line
//   Enable       in   0 blocks capture of Entrada
//   Ack          in   consumer acknowledge of the presented code
//   Salida[1:0]  out  index of the line being served (held while idle)
//   Valido       out  Salida holds a code awaiting Ack
//   Ninguno      out  no request pending
//   Pendientes   out  pending-request register
//   Contador     out  acknowledged codes, modulo 16
//   estado_dbg_o out  FSM state (0 = INACTIVO, 1 = PRESENTANDO)
module codificador_4a2 #(
  parameter bit ALTA_PRIMERO = 1'b1
) (
  input  logic       Reloj,
  input  logic       Reset,
  input  logic [3:0] Entrada,
  input  logic       Enable,
  input  logic       Ack,
  output logic [1:0] Salida,
  output logic       Valido,
  output logic       Ninguno,
  output logic [3:0] Pendientes,
  output logic [3:0] Contador,
  output logic       estado_dbg_o
);

  typedef enum logic {
    INACTIVO    = 1'b0,
    PRESENTANDO = 1'b1
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] salida_q, salida_d;
  logic [3:0] cont_q, cont_d;
  logic [3:0] clr_mask;
  logic [1:0] prio_idx;

  // Highest-priority pending index. When nothing is pending the value is
  // unused, because the FSM only loads it when pend_q is nonzero.
  always_comb begin
    prio_idx = 2'd0;
    if (ALTA_PRIMERO) begin
      if      (pend_q[3]) prio_idx = 2'd3;
      else if (pend_q[2]) prio_idx = 2'd2;
      else if (pend_q[1]) prio_idx = 2'd1;
      else                prio_idx = 2'd0;
    end else begin
      if      (pend_q[0]) prio_idx = 2'd0;
      else if (pend_q[1]) prio_idx = 2'd1;
      else if (pend_q[2]) prio_idx = 2'd2;
      else                prio_idx = 2'd3;
    end
  end

  // Next-state logic. Salida is loaded only on INACTIVO->PRESENTANDO, so a
  // request that arrives later cannot change the code being presented.
  always_comb begin
    estado_d = estado_q;
    salida_d = salida_q;
    cont_d   = cont_q;
    clr_mask = 4'b0000;
    case (estado_q)
      INACTIVO: begin
        if (pend_q != 4'b0000) begin
          estado_d = PRESENTANDO;
          salida_d = prio_idx;
        end
      end
      PRESENTANDO: begin
        if (Ack) begin
          clr_mask = 4'b0001 << salida_q;
          cont_d   = cont_q + 4'd1;
          estado_d = INACTIVO;
        end
      end
      default: estado_d = INACTIVO;
    endcase
    // The set is OR-ed in after the clear, so a new request on the line being
    // acknowledged survives the same edge.
    pend_d = (pend_q & ~clr_mask) | (Entrada & {4{Enable}});
  end

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      estado_q <= INACTIVO;
      pend_q   <= 4'b0000;
      salida_q <= 2'b00;
      cont_q   <= 4'b0000;
    end else begin
      estado_q <= estado_d;
      pend_q   <= pend_d;
      salida_q <= salida_d;
      cont_q   <= cont_d;
    end
  end

  assign Salida       = salida_q;
  assign Valido       = (estado_q == PRESENTANDO);
  assign Ninguno      = (pend_q == 4'b0000);
  assign Pendientes   = pend_q;
  assign Contador     = cont_q;
  assign estado_dbg_o = (estado_q == PRESENTANDO);

endmodule

// File: tb/tb_codificador_4a2.sv
// Testbench for codificador_4a2. Two instances share all inputs: dut_a has
// ALTA_PRIMERO=1 and dut_b has ALTA_PRIMERO=0. Most checks look at dut_a; the
// priority test checks both. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point.
module tb_codificador_4a2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] entrada;
  logic       enable;
  logic       ack;

  logic [1:0] sal_a, sal_b;
  logic       val_a, val_b, nin_a, nin_b, st_a, st_b;
  logic [3:0] pen_a, pen_b, cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  codificador_4a2 #(.ALTA_PRIMERO(1'b1)) dut_a (
    .Reloj(clk), .Reset(rst), .Entrada(entrada), .Enable(enable), .Ack(ack),
    .Salida(sal_a), .Valido(val_a), .Ninguno(nin_a), .Pendientes(pen_a),
    .Contador(cnt_a), .estado_dbg_o(st_a)
  );

  codificador_4a2 #(.ALTA_PRIMERO(1'b0)) dut_b (
    .Reloj(clk), .Reset(rst), .Entrada(entrada), .Enable(enable), .Ack(ack),
    .Salida(sal_b), .Valido(val_b), .Ninguno(nin_b), .Pendientes(pen_b),
    .Contador(cnt_b), .estado_dbg_o(st_b)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic v, input logic [1:0] s,
                         input logic [3:0] p, input logic n, input logic [3:0] c);
    check({tag, ".valido"},     {7'd0, val_a}, {7'd0, v});
    check({tag, ".salida"},     {6'd0, sal_a}, {6'd0, s});
    check({tag, ".pendientes"}, {4'd0, pen_a}, {4'd0, p});
    check({tag, ".ninguno"},    {7'd0, nin_a}, {7'd0, n});
    check({tag, ".contador"},   {4'd0, cnt_a}, {4'd0, c});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; entrada = 4'b0; enable = 1'b1; ack = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse(input logic [3:0] e);
    entrada = e;
    step();
    entrada = 4'b0;
  endtask

  // Wait (bounded) until dut_a presents a code; an expired bound fails.
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 6; i++) begin
      if (val_a) break;
      step();
    end
    check({tag, ".wait_valid"}, {7'd0, val_a}, 8'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] ent;
    logic       en;
    logic       ak;
    logic       v;
    logic [1:0] s;
    logic [3:0] p;
    logic       n;
    logic [3:0] c;
  } vec_t;

  vec_t vecs[6];

  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];

  initial begin
    // Single request: capture, present, acknowledge, then hold Salida while idle.
    vecs[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 4'd0};
    vecs[1] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'b10, 4'b0100, 1'b0, 4'd0};
    vecs[2] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'b10, 4'b0100, 1'b0, 4'd0};
    vecs[3] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, 4'd1};
    vecs[4] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0000, 1'b1, 4'd1};
    vecs[5] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, 4'd1};

    // Reset state, asynchronously, before any clock edge.
    rst = 1'b1; entrada = 4'b0; enable = 1'b0; ack = 1'b0;
    #2;
    check_a("reset0", 1'b0, 2'b00, 4'b0000, 1'b1, 4'd0);
    check("reset0.b_ninguno", {7'd0, nin_b}, 8'd1);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      entrada = vecs[i].ent; enable = vecs[i].en; ack = vecs[i].ak;
      step();
      check_a($sformatf("vec%0d", i), vecs[i].v, vecs[i].s, vecs[i].p, vecs[i].n, vecs[i].c);
    end
    ack = 1'b0; entrada = 4'b0;

    // Priority, both parameter settings, with a shared acknowledge.
    do_reset();
    exp_a = '{2'b11, 2'b01, 2'b00};
    exp_b = '{2'b00, 2'b01, 2'b11};
    pulse(4'b1011);
    check("prio.pend_a", {4'd0, pen_a}, 8'h0b);
    for (int k = 0; k < 3; k++) begin
      wait_valid("prio");
      check($sformatf("prio.code_a%0d", k), {6'd0, sal_a}, {6'd0, exp_a.pop_front()});
      check($sformatf("prio.code_b%0d", k), {7'd0, val_b, sal_b}, {7'd1, exp_b.pop_front()});
      do_ack();
      check($sformatf("prio.gap%0d", k), {7'd0, val_a}, 8'd0);
    end
    check("prio.cnt_a", {4'd0, cnt_a}, 8'd3);
    check("prio.cnt_b", {4'd0, cnt_b}, 8'd3);
    check("prio.ninguno_b", {7'd0, nin_b}, 8'd1);

    // Stability: a higher-priority request does not disturb the presented code.
    do_reset();
    pulse(4'b0010);
    wait_valid("stab");
    check("stab.code", {6'd0, sal_a}, 8'd1);
    pulse(4'b1000);
    step(); step();
    check("stab.hold_sal", {6'd0, sal_a}, 8'd1);
    check("stab.hold_val", {7'd0, val_a}, 8'd1);
    check("stab.pend", {4'd0, pen_a}, 8'h0a);
    do_ack();
    wait_valid("stab2");
    check("stab.next", {6'd0, sal_a}, 8'd3);
    do_ack();

    // Simultaneous set and clear on line 2.
    do_reset();
    pulse(4'b0100);
    wait_valid("simul");
    check("simul.code", {6'd0, sal_a}, 8'd2);
    entrada = 4'b0100; ack = 1'b1;
    step();
    entrada = 4'b0; ack = 1'b0;
    check_a("simul.after", 1'b0, 2'b10, 4'b0100, 1'b0, 4'd1);
    step();
    check("simul.again_val", {7'd0, val_a}, 8'd1);
    check("simul.again_sal", {6'd0, sal_a}, 8'd2);
    do_ack();

    // Enable gating, and Ack in INACTIVO ignored.
    do_reset();
    enable = 1'b0; entrada = 4'b1111;
    step(); step(); step();
    check("gate.pend", {4'd0, pen_a}, 8'h00);
    check("gate.val", {7'd0, val_a}, 8'd0);
    entrada = 4'b0; ack = 1'b1;
    step(); step();
    ack = 1'b0;
    check("gate.cnt", {4'd0, cnt_a}, 8'd0);
    // A request already pending is still served with Enable low.
    enable = 1'b1;
    pulse(4'b0001);
    enable = 1'b0;
    wait_valid("gate2");
    check("gate.serve_sal", {6'd0, sal_a}, 8'd0);
    do_ack();
    check("gate.serve_cnt", {4'd0, cnt_a}, 8'd1);
    enable = 1'b1;

    // Counter wrap after 16 acknowledged codes.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      pulse(4'b0001);
      wait_valid("wrap");
      do_ack();
      if (k == 14) check("wrap.cnt15", {4'd0, cnt_a}, 8'd15);
    end
    check("wrap.cnt0", {4'd0, cnt_a}, 8'd0);

    // Reset in the middle of PRESENTANDO acts without a clock edge.
    pulse(4'b1000);
    wait_valid("midrst");
    check("midrst.pend", {4'd0, pen_a}, 8'h08);
    #2;
    rst = 1'b1;
    #1;
    check_a("midrst", 1'b0, 2'b00, 4'b0000, 1'b1, 4'd0);
    // Inputs are ignored on an edge while Reset is high.
    entrada = 4'b1111; ack = 1'b1;
    step();
    check_a("rsthold", 1'b0, 2'b00, 4'b0000, 1'b1, 4'd0);
    entrada = 4'b0; ack = 1'b0; rst = 1'b0;
    step();
    check("postrst.pend", {4'd0, pen_a}, 8'h00);
    check("postrst.cnt", {4'd0, cnt_a}, 8'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/codificador_4a2.md
CODIFICADOR_4A2 -- requirements
Module: codificador_4a2

Interface
REQ-001 SHALL have parameter: ALTA_PRIMERO, 1, 1 = Entrada[3] highest priority; 0 = Entrada[0] highest priority.
REQ-002 SHALL have port: Reloj  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Entrada  input  4  request strobes, one bit per line, sampled each rising edge.
REQ-005 SHALL have port: Enable  input  1  gates request capture; 0 = Entrada ignored.
REQ-006 SHALL have port: Ack  input  1  consumer acknowledge of presented code.
REQ-007 SHALL have port: Salida  output  2  binary code of the line being served.
REQ-008 SHALL have port: Valido  output  1  Salida holds a code awaiting Ack.
REQ-009 SHALL have port: Ninguno  output  1  high when no request is pending.
REQ-010 SHALL have port: Pendientes  output  4  pending-request register, bit i = line i pending.
REQ-011 SHALL have port: Contador  output  4  count of acknowledged codes, modulo 16.

Function
REQ-012 SHALL capture requests sticky: each edge, Pendientes <= (Pendientes | (Entrada & {4{Enable}})) with the served bit cleared per REQ-017.
REQ-013 SHALL give a set higher precedence than a clear: if Entrada[i] and Enable are high on the same edge that clears bit i, bit i stays 1 (new request).
REQ-014 SHALL implement a 2-state FSM: INACTIVO (Valido=0) and PRESENTANDO (Valido=1); Valido is decoded from state only.
REQ-015 SHALL, in INACTIVO with Pendientes != 0, move to PRESENTANDO on the next edge and load Salida with the highest-priority pending index per ALTA_PRIMERO; INACTIVO with Pendientes == 0 stays INACTIVO.
REQ-016 SHALL keep Salida stable throughout PRESENTANDO, even if a higher-priority request arrives.
REQ-017 SHALL, in PRESENTANDO with Ack=1 at an edge, clear Pendientes[Salida], increment Contador (15 wraps to 0), and return to INACTIVO.
REQ-018 SHALL stay in PRESENTANDO while Ack=0; no timeout.
REQ-019 SHALL ignore Ack in INACTIVO: no clear, no count.
REQ-020 SHALL hold Valido low for at least one cycle between consecutive codes, because every Ack returns to INACTIVO.
REQ-021 SHALL have a latency of 2 edges from Entrada[i] high (Enable=1) to Valido high: edge 1 captures the request, edge 2 enters PRESENTANDO.
REQ-022 SHALL let Enable=0 block only capture; already pending requests are still presented and served.
REQ-023 SHALL hold the last Salida value in INACTIVO.
REQ-024 SHALL drive Ninguno combinationally as (Pendientes == 0).

Reset
REQ-025 SHALL, on Reset=1, immediately and asynchronously force: state INACTIVO, Valido=0, Salida=00, Pendientes=0000, Ninguno=1, Contador=0000.
REQ-026 SHALL discard any in-progress presentation on Reset asserted mid-PRESENTANDO; the lost code is not counted.
REQ-027 SHALL ignore Entrada and Ack on the first edge while Reset is high; normal capture begins at the first edge after Reset falls.

Verification
REQ-028 SHALL cover single request: Enable=1, Entrada=0100 for 1 cycle -> Pendientes=0100 after edge 1; Valido=1, Salida=10 after edge 2; Ack for 1 cycle -> Valido=0, Pendientes=0000, Contador=1, Ninguno=1.
REQ-029 SHALL cover priority: Entrada=1011 pulsed, ALTA_PRIMERO=1 -> codes 11, 01, 00 in order, each acked, Contador=3; the same test with ALTA_PRIMERO=0 -> codes 00, 01, 11.
REQ-030 SHALL cover stability: while presenting Salida=01, pulse Entrada=1000 -> Salida stays 01 until Ack; the next code is 11.
REQ-031 SHALL cover simultaneous set and clear: Ack on code 10 on the same edge Entrada=0100 -> Pendientes[2]=1; code 10 is presented again after 1 idle cycle.
REQ-032 SHALL cover Enable gating: Enable=0, Entrada=1111 -> Pendientes stays 0000 and Valido stays 0; Ack in INACTIVO -> Contador unchanged.
REQ-033 SHALL cover reset and wrap: 16 acked codes -> Contador=0000; Reset asserted mid-PRESENTANDO -> all outputs at reset values with no clock edge required.
